// File: rtl/bcd_ndigit_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake and overflow saturation.
// Optional leading-zero blanking output is enabled by defining BCD_BLANK_EN.
module bcd_ndigit_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
`ifdef BCD_BLANK_EN
    output logic [DIGITS-1:0]     blank,
`endif
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;

    function automatic logic [63:0] pow10_m1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = pow10_m1(DIGITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [AW-1:0]    acc_adj;
    logic             is_ovf;

    // Every digit >= 5 gets +3 before the shift so it carries correctly into the next digit.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
        end
    end

    assign is_ovf = (64'(val_q) > MAXV);

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
    logic [DIGITS:0]   hz;

    always_comb begin
        hz          = '0;
        hz[DIGITS]  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) hz[k] = hz[k+1] && (acc_q[4*k +: 4] == 4'd0);
        blank_nx    = '0;
        for (int k = 1; k < DIGITS; k++) blank_nx[k] = hz[k];
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        val_d   = val_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef BCD_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d    = value;
                    val_d   = value;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = {acc_adj[AW-2:0], sh_q[WIDTH-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                ovf_d   = is_ovf;
                bcd_d   = is_ovf ? {DIGITS{4'h9}} : acc_q;
                done_d  = 1'b1;
`ifdef BCD_BLANK_EN
                blank_d = is_ovf ? '0 : blank_nx;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            val_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            val_q   <= val_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign busy = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd  = bcd_q;
`ifdef BCD_BLANK_EN
    assign blank = blank_q;
`endif
endmodule
